// File: rtl/sxt1_fifo_pkg.sv
// Shared SXT1 FIFO definitions: default geometry and width helpers used by the
// read- and write-side stages.
package sxt1_fifo_pkg;

  localparam int unsigned SXT1_DATA_WIDTH_DEF = 32;
  localparam int unsigned SXT1_RD_LATENCY_DEF = 1;
  localparam int unsigned SXT1_BUF_EXTRA      = 2;

  // Ceiling log2 with clog2(0) = clog2(1) = 0, matching $clog2.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned buf_depth(input int unsigned rd_latency);
    return rd_latency + SXT1_BUF_EXTRA;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (clog2(depth) == 0) ? 1 : clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_count);
    return (clog2(max_count + 1) == 0) ? 1 : clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sxt1_fifo_fwft_rd_stage_if.sv
// First-word-fall-through output stream of the SXT1 read stage.
interface sxt1_fifo_fwft_rd_stage_if #(
  parameter int unsigned c_DATA_WIDTH = 32
) ();

  logic                    m_valid;
  logic [c_DATA_WIDTH-1:0] m_data;
  logic                    m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/sxt1_fifo_obuf.sv
// Circular output buffer for the SXT1 FWFT read stage: push/pop, pointers,
// occupancy and registered head word.
module sxt1_fifo_obuf
  import sxt1_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = 32,
  parameter int unsigned c_BUF_DEPTH  = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             push_i,
  input  logic [c_DATA_WIDTH-1:0]          push_data_i,
  input  logic                             pop_i,
  output logic [cnt_w(c_BUF_DEPTH)-1:0]    occ_o,
  output logic [c_DATA_WIDTH-1:0]          head_o
);

  localparam int unsigned PTR_W = ptr_w(c_BUF_DEPTH);
  localparam int unsigned CNT_W = cnt_w(c_BUF_DEPTH);

  logic [c_DATA_WIDTH-1:0] mem_q [c_BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        occ_q, occ_d;
  logic                    pop_eff;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(c_BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop_eff  = pop_i && (occ_q != '0);
    wr_ptr_d = push_i  ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_eff ? next_ptr(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    case ({push_i, pop_eff})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared on reset so the head word reads zero afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < c_BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_comb begin
    occ_o  = occ_q;
    head_o = mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/sxt1_fifo_fwft_rd_stage.sv
// SXT1 FIFO read-side FWFT stage: credit-based read issue, return tracking and
// output buffer. Optional occupancy port under `SXT1_FWFT_LEVEL_EN.
module sxt1_fifo_fwft_rd_stage
  import sxt1_fifo_pkg::*;
#(
  parameter int unsigned c_DATA_WIDTH = SXT1_DATA_WIDTH_DEF,
  parameter int unsigned c_RD_LATENCY = SXT1_RD_LATENCY_DEF
) (
  input  logic                                        rclk,
  input  logic                                        rrst,
  input  logic                                        fifo_rempty,
  output logic                                        fifo_r_en,
  input  logic [c_DATA_WIDTH-1:0]                     ram_rd_data,
`ifdef SXT1_FWFT_LEVEL_EN
  output logic [cnt_w(buf_depth(c_RD_LATENCY))-1:0]   o_level,
`endif
  sxt1_fifo_fwft_rd_stage_if.master                   m
);

  localparam int unsigned c_BUF_DEPTH = buf_depth(c_RD_LATENCY);
  localparam int unsigned CNT_W       = cnt_w(c_BUF_DEPTH);
  localparam int unsigned CRD_W       = CNT_W + 1;
  localparam int unsigned INFL_W      = cnt_w(c_RD_LATENCY);

  logic [CNT_W-1:0]        occ;
  logic [CRD_W-1:0]        credit;
  logic [INFL_W-1:0]       inflight_q, inflight_d;
  logic [c_RD_LATENCY-1:0] vpipe_q, vpipe_d;
  logic                    ret;
  logic                    pop;

  // Issue uses only registered counts, so m_ready never reaches fifo_r_en.
  always_comb begin
    credit    = CRD_W'(occ) + CRD_W'(inflight_q);
    fifo_r_en = !rrst && !fifo_rempty && (credit < CRD_W'(c_BUF_DEPTH));
  end

  always_comb begin
    vpipe_d[0] = fifo_r_en;
    for (int unsigned i = 1; i < c_RD_LATENCY; i++) vpipe_d[i] = vpipe_q[i-1];
    ret = vpipe_q[c_RD_LATENCY-1];
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({fifo_r_en, ret})
      2'b10:   inflight_d = inflight_q + INFL_W'(1);
      2'b01:   inflight_d = inflight_q - INFL_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      vpipe_q    <= '0;
      inflight_q <= '0;
    end else begin
      vpipe_q    <= vpipe_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    m.m_valid = (occ != '0);
    pop       = m.m_valid && m.m_ready;
  end

  sxt1_fifo_obuf #(
    .c_DATA_WIDTH (c_DATA_WIDTH),
    .c_BUF_DEPTH  (c_BUF_DEPTH)
  ) u_obuf (
    .clk_i       (rclk),
    .rst_i       (rrst),
    .push_i      (ret),
    .push_data_i (ram_rd_data),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_o      (m.m_data)
  );

`ifdef SXT1_FWFT_LEVEL_EN
  logic [CNT_W-1:0] level_q, level_d;

  // A return moves a word from inflight to occ, so the sum changes only on issue and pop.
  always_comb begin
    level_d = level_q + CNT_W'(fifo_r_en) - CNT_W'(pop);
  end

  always_ff @(posedge rclk) begin
    if (rrst) level_q <= '0;
    else      level_q <= level_d;
  end

  always_comb o_level = level_q;
`endif

endmodule

// File: tb/tb_sxt1_fifo_fwft_rd_stage.sv
// Directed bench for sxt1_fifo_fwft_rd_stage: one DUT at read latency 1, one at 2,
// each fed by a small FIFO controller/RAM model.
module tb_sxt1_fifo_fwft_rd_stage;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  logic rclk;
  logic rrst;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // ---------------- DUT A: c_RD_LATENCY = 1 ----------------
  logic [31:0]  mem_a [64];
  int unsigned  wp_a = 0;
  int unsigned  rp_a = 0;
  logic         rempty_a;
  logic         r_en_a;
  logic [31:0]  rdp_a;
  logic [1:0]   lvl_a;

  assign rempty_a = (rp_a == wp_a);

  always @(posedge rclk) begin
    if (rrst)        rp_a <= 0;
    else if (r_en_a) rp_a <= rp_a + 1;
    rdp_a <= r_en_a ? mem_a[rp_a % 64] : 32'hBAD0_00AA;
  end

  sxt1_fifo_fwft_rd_stage_if #(.c_DATA_WIDTH(32)) if_a ();

  sxt1_fifo_fwft_rd_stage #(
    .c_DATA_WIDTH (32),
    .c_RD_LATENCY (1)
  ) u_dut_a (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_rempty (rempty_a),
    .fifo_r_en   (r_en_a),
    .ram_rd_data (rdp_a),
`ifdef SXT1_FWFT_LEVEL_EN
    .o_level     (lvl_a),
`endif
    .m           (if_a)
  );

  // ---------------- DUT B: c_RD_LATENCY = 2 ----------------
  logic [31:0]  mem_b [64];
  int unsigned  wp_b = 0;
  int unsigned  rp_b = 0;
  logic         rempty_b;
  logic         r_en_b;
  logic [31:0]  rdp_b0, rdp_b1;
  logic [2:0]   lvl_b;

  assign rempty_b = (rp_b == wp_b);

  always @(posedge rclk) begin
    if (rrst)        rp_b <= 0;
    else if (r_en_b) rp_b <= rp_b + 1;
    rdp_b0 <= r_en_b ? mem_b[rp_b % 64] : 32'hBAD0_00BB;
    rdp_b1 <= rdp_b0;
  end

  sxt1_fifo_fwft_rd_stage_if #(.c_DATA_WIDTH(32)) if_b ();

  sxt1_fifo_fwft_rd_stage #(
    .c_DATA_WIDTH (32),
    .c_RD_LATENCY (2)
  ) u_dut_b (
    .rclk        (rclk),
    .rrst        (rrst),
    .fifo_rempty (rempty_b),
    .fifo_r_en   (r_en_b),
    .ram_rd_data (rdp_b1),
`ifdef SXT1_FWFT_LEVEL_EN
    .o_level     (lvl_b),
`endif
    .m           (if_b)
  );

`ifndef SXT1_FWFT_LEVEL_EN
  assign lvl_a = '0;
  assign lvl_b = '0;
`endif

  task automatic load_a(input logic [31:0] w);
    mem_a[wp_a % 64] = w;
    wp_a++;
  endtask

  task automatic load_b(input logic [31:0] w);
    mem_b[wp_b % 64] = w;
    wp_b++;
  endtask

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    rrst = 1'b1;
    if_a.m_ready = 1'b1;
    if_b.m_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) load_a(32'(i + 1));

    // Reset with A non-empty
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_r_en_a", r_en_a, 1'b0);
      chk("rst_valid_a", if_a.m_valid, 1'b0);
      chk("rst_data_a", if_a.m_data, 32'h0);
      chk("rst_r_en_b", r_en_b, 1'b0);
`ifdef SXT1_FWFT_LEVEL_EN
      chk("rst_level_a", lvl_a, 2'd0);
`endif
    end

    // Stream, latency 1
    rrst = 1'b0; #1;
    chk("stream_issue0", r_en_a, 1'b1);
    chk("stream_valid_c0", if_a.m_valid, 1'b0);
    cyc(); #1;
    chk("stream_valid_c1", if_a.m_valid, 1'b0);
    chk("stream_issue1", r_en_a, 1'b1);
`ifdef SXT1_FWFT_LEVEL_EN
    chk("stream_level_c1", lvl_a, 2'd1);
`endif
    for (int unsigned k = 0; k < 8; k++) begin
      cyc(); #1;
      chk("stream_valid", if_a.m_valid, 1'b1);
      chk("stream_data", if_a.m_data, 32'(k + 1));
`ifdef SXT1_FWFT_LEVEL_EN
      if (k == 0) chk("stream_level_ss", lvl_a, 2'd2);
`endif
    end
    cyc(); #1;
    chk("stream_end_valid", if_a.m_valid, 1'b0);
    chk("stream_end_r_en", r_en_a, 1'b0);

    // Backpressure, latency 1
    if_a.m_ready = 1'b0;
    for (int unsigned i = 0; i < 8; i++) load_a(32'h11 + 32'(i));
    #1;
    chk("bp_issue0", r_en_a, 1'b1);
    cyc(); #1;
    chk("bp_issue1", r_en_a, 1'b1);
    cyc(); #1;
    chk("bp_issue2", r_en_a, 1'b1);
    chk("bp_head_valid", if_a.m_valid, 1'b1);
    chk("bp_head_data", if_a.m_data, 32'h11);
    cyc(); #1;
    chk("bp_full_stop", r_en_a, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("bp_hold_r_en", r_en_a, 1'b0);
      chk("bp_hold_valid", if_a.m_valid, 1'b1);
      chk("bp_hold_data", if_a.m_data, 32'h11);
`ifdef SXT1_FWFT_LEVEL_EN
      chk("bp_hold_level", lvl_a, 2'd3);
`endif
    end
    cyc();
    if_a.m_ready = 1'b1;
    #1;
    chk("bp_rel_data", if_a.m_data, 32'h11);
    chk("bp_rel_r_en", r_en_a, 1'b0);
    for (int unsigned k = 1; k < 8; k++) begin
      cyc(); #1;
      chk("bp_drain_valid", if_a.m_valid, 1'b1);
      chk("bp_drain_data", if_a.m_data, 32'h11 + 32'(k));
    end
    cyc(); #1;
    chk("bp_end_valid", if_a.m_valid, 1'b0);
    chk("bp_end_r_en", r_en_a, 1'b0);

    // Single word, latency 1
    load_a(32'h55);
    #1;
    chk("one_issue", r_en_a, 1'b1);
    cyc(); #1;
    chk("one_no_reissue", r_en_a, 1'b0);
    chk("one_valid_e1", if_a.m_valid, 1'b0);
    cyc(); #1;
    chk("one_valid_e2", if_a.m_valid, 1'b1);
    chk("one_data", if_a.m_data, 32'h55);
    chk("one_r_en_e2", r_en_a, 1'b0);
    cyc(); #1;
    chk("one_valid_e3", if_a.m_valid, 1'b0);
    chk("one_r_en_e3", r_en_a, 1'b0);

    // Simultaneous push/pop, latency 2
    for (int unsigned i = 0; i < 8; i++) load_b(32'h21 + 32'(i));
    #1;
    chk("pp_issue0", r_en_b, 1'b1);
    for (int unsigned i = 0; i < 2; i++) begin
      cyc(); #1;
      chk("pp_issue_fill", r_en_b, 1'b1);
      chk("pp_valid_fill", if_b.m_valid, 1'b0);
    end
    for (int unsigned k = 0; k < 8; k++) begin
      cyc(); #1;
      chk("pp_valid", if_b.m_valid, 1'b1);
      chk("pp_data", if_b.m_data, 32'h21 + 32'(k));
`ifdef SXT1_FWFT_LEVEL_EN
      if (k < 5) chk("pp_level", lvl_b, 3'd3);
`endif
    end
    cyc(); #1;
    chk("pp_end_valid", if_b.m_valid, 1'b0);

    // Mid-stream reset, latency 2
    if_b.m_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) load_b(32'h31 + 32'(i));
    #1;
    chk("mr_issue0", r_en_b, 1'b1);
    cyc(); #1;
    cyc(); #1;
    cyc(); #1;
    chk("mr_valid_g3", if_b.m_valid, 1'b1);
    chk("mr_data_g3", if_b.m_data, 32'h31);
    cyc(); #1;
    chk("mr_full_r_en", r_en_b, 1'b0);
    chk("mr_data_g4", if_b.m_data, 32'h31);
`ifdef SXT1_FWFT_LEVEL_EN
    chk("mr_level_g4", lvl_b, 3'd4);
`endif
    rrst = 1'b1;
    wp_a = 0;
    wp_b = 0;
    if_b.m_ready = 1'b1;
    #1;
    chk("mr_rst_r_en", r_en_b, 1'b0);
    cyc();
    rrst = 1'b0;
    #1;
    chk("mr_after_valid", if_b.m_valid, 1'b0);
    chk("mr_after_data", if_b.m_data, 32'h0);
    chk("mr_after_r_en", r_en_b, 1'b0);
    chk("mr_after_valid_a", if_a.m_valid, 1'b0);
`ifdef SXT1_FWFT_LEVEL_EN
    chk("mr_after_level", lvl_b, 3'd0);
`endif
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("mr_late_valid", if_b.m_valid, 1'b0);
      chk("mr_late_r_en", r_en_b, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
